// File: rtl/sram_rmw_bridge.sv
// Request/response front-end for the 512x32 single-port SRAM wrapper.
// Byte-strobed partial writes become read-modify-write sequences (RD, CAP, WR),
// because the wrapper has no byte-write mask. One access is in flight at a time.
module sram_rmw_bridge #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    // Request channel
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_we,
    input  logic [3:0]        req_be,
    input  logic [DATA_W-1:0] req_wdata,

    // Response channel
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,

    // SRAM wrapper side
    output logic              sram_en,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_wen,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int unsigned NumLanes = 4;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StCap,
        StWr,
        StResp
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [3:0]          be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   merge_q, merge_d;
    logic [DATA_W-1:0]   rsp_q, rsp_d;
    logic [DATA_W-1:0]   merged;

    // Lane merge of the captured SRAM word with the latched write data
    always_comb begin
        merged = '0;
        for (int i = 0; i < NumLanes; i++) begin
            merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : sram_rdata[8*i +: 8];
        end
    end

    // State and data registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            merge_q <= merge_d;
            rsp_q   <= rsp_d;
        end
    end

    // Next-state, datapath updates and output decode from registered state
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        merge_d    = merge_q;
        rsp_d      = rsp_q;

        // req_ready also reads 1 while reset is held low
        req_ready  = (state_q == StIdle) || !reset;
        rsp_valid  = (state_q == StResp);
        rsp_rdata  = rsp_q;
        sram_en    = 1'b0;
        sram_wen   = 1'b0;
        sram_addr  = addr_q;
        sram_wdata = '0;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    we_d    = req_we;
                    be_d    = req_be;
                    wdata_d = req_wdata;
                    merge_d = req_wdata;
                    rsp_d   = '0;
                    if (!req_we || (req_be != 4'b0000 && req_be != 4'b1111)) begin
                        state_d = StRd;
                    end else if (req_be == 4'b1111) begin
                        state_d = StWr;
                    end else begin
                        // Empty strobe: nothing to store, answer with zero
                        state_d = StResp;
                    end
                end
            end
            StRd: begin
                sram_en = 1'b1;
                state_d = StCap;
            end
            StCap: begin
                // SRAM read data is valid here; this idle cycle also spaces the strobes
                if (!we_q) begin
                    rsp_d   = sram_rdata;
                    state_d = StResp;
                end else begin
                    merge_d = merged;
                    state_d = StWr;
                end
            end
            StWr: begin
                sram_en    = 1'b1;
                sram_wen   = 1'b1;
                sram_wdata = merge_q;
                rsp_d      = merge_q;
                state_d    = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_rmw_bridge.sv
// Directed bench for sram_rmw_bridge with a behavioural 512x32 SRAM model.
module tb_sram_rmw_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [8:0]  req_addr = '0;
    logic        req_we = 1'b0;
    logic [3:0]  req_be = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        sram_en;
    logic [8:0]  sram_addr;
    logic        sram_wen;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata = '0;

    logic [31:0] mem [512];

    int total = 0;
    int bad = 0;
    int adj_viol = 0;
    int zero_viol = 0;
    int addr_viol = 0;

    always #5 clk = ~clk;

    sram_rmw_bridge #(.ADDR_W(9), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_be    (req_be),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .sram_en   (sram_en),
        .sram_addr (sram_addr),
        .sram_wen  (sram_wen),
        .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata)
    );

    // SRAM model: one-cycle read latency, rdata holds between reads
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_wen) mem[sram_addr] <= sram_wdata;
            else          sram_rdata <= mem[sram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Issue one request, watch the SRAM side until rsp_valid, optionally stall the response
    task automatic do_req(input logic [8:0] a, input logic we, input logic [3:0] be,
                          input logic [31:0] wd, input int stall,
                          output int lat, output int en_cnt, output int wen_cnt,
                          output logic [31:0] wdat, output logic [31:0] rdat,
                          output int unstable);
        logic prev;
        lat = 0; en_cnt = 0; wen_cnt = 0; wdat = '0; rdat = '0; unstable = 0; prev = 1'b0;
        @(negedge clk);
        check("ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_addr = a; req_we = we; req_be = be; req_wdata = wd;
        @(posedge clk);
        #1;
        // Scramble request fields while not ready; the bridge must ignore them
        req_valid = 1'b1; req_addr = ~a; req_we = ~we; req_be = ~be; req_wdata = ~wd;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (sram_en) begin
                en_cnt++;
                if (prev) adj_viol++;
                if (sram_addr !== a) addr_viol++;
                if (sram_wen) begin
                    wen_cnt++;
                    wdat = sram_wdata;
                end
            end else if (sram_wen !== 1'b0 || sram_wdata !== 32'h0) begin
                zero_viol++;
            end
            prev = sram_en;
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
        rdat = rsp_rdata;
        for (int s = 1; s < stall; s++) begin
            @(negedge clk);
            if (rsp_rdata !== rdat || rsp_valid !== 1'b1 || req_ready !== 1'b0) unstable++;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        int lat, en_cnt, wen_cnt, unstable, cnt;
        logic [31:0] wdat, rdat;

        // Reset held low for three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_ready", {31'b0, req_ready}, 32'd1);
            check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
            check("rst_sram_en", {31'b0, sram_en}, 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        check("rel_ready", {31'b0, req_ready}, 32'd1);
        check("rel_sram_wen", {31'b0, sram_wen}, 32'd0);
        check("rel_sram_addr", {23'b0, sram_addr}, 32'd0);
        check("rel_sram_wdata", sram_wdata, 32'd0);
        check("rel_rsp_rdata", rsp_rdata, 32'd0);

        // Full write then read back
        do_req(9'h1A5, 1'b1, 4'b1111, 32'hDEADBEEF, 1, lat, en_cnt, wen_cnt, wdat, rdat, unstable);
        check("fw_lat", lat, 2);
        check("fw_en", en_cnt, 1);
        check("fw_wen", wen_cnt, 1);
        check("fw_wdata", wdat, 32'hDEADBEEF);
        check("fw_rsp", rdat, 32'hDEADBEEF);

        do_req(9'h1A5, 1'b0, 4'b0000, 32'h0, 1, lat, en_cnt, wen_cnt, wdat, rdat, unstable);
        check("rd_lat", lat, 3);
        check("rd_en", en_cnt, 1);
        check("rd_wen", wen_cnt, 0);
        check("rd_rsp", rdat, 32'hDEADBEEF);

        // Partial write on lane 1
        do_req(9'h1A5, 1'b1, 4'b0010, 32'h00005500, 1, lat, en_cnt, wen_cnt, wdat, rdat, unstable);
        check("pw_lat", lat, 4);
        check("pw_en", en_cnt, 2);
        check("pw_wen", wen_cnt, 1);
        check("pw_wdata", wdat, 32'hDEAD55EF);
        check("pw_rsp", rdat, 32'hDEAD55EF);

        do_req(9'h1A5, 1'b0, 4'b1111, 32'h0, 1, lat, en_cnt, wen_cnt, wdat, rdat, unstable);
        check("pw_readback", rdat, 32'hDEAD55EF);

        // Partial write on lanes 3 and 0 of another word
        do_req(9'h0FF, 1'b1, 4'b1111, 32'h11223344, 1, lat, en_cnt, wen_cnt, wdat, rdat, unstable);
        do_req(9'h0FF, 1'b1, 4'b1001, 32'hAABBCCDD, 1, lat, en_cnt, wen_cnt, wdat, rdat, unstable);
        check("pw2_rsp", rdat, 32'hAA2233DD);
        do_req(9'h0FF, 1'b0, 4'b0000, 32'h0, 1, lat, en_cnt, wen_cnt, wdat, rdat, unstable);
        check("pw2_readback", rdat, 32'hAA2233DD);

        // Empty strobe write leaves the word untouched
        do_req(9'h000, 1'b1, 4'b1111, 32'h0BADF00D, 1, lat, en_cnt, wen_cnt, wdat, rdat, unstable);
        do_req(9'h000, 1'b1, 4'b0000, 32'hFFFFFFFF, 1, lat, en_cnt, wen_cnt, wdat, rdat, unstable);
        check("be0_lat", lat, 1);
        check("be0_en", en_cnt, 0);
        check("be0_rsp", rdat, 32'h0);
        do_req(9'h000, 1'b0, 4'b0000, 32'h0, 1, lat, en_cnt, wen_cnt, wdat, rdat, unstable);
        check("be0_readback", rdat, 32'h0BADF00D);

        // Response stalled for five cycles
        do_req(9'h1A5, 1'b0, 4'b0000, 32'h0, 5, lat, en_cnt, wen_cnt, wdat, rdat, unstable);
        check("stall_lat", lat, 3);
        check("stall_rsp", rdat, 32'hDEAD55EF);
        check("stall_stable", unstable, 0);
        @(negedge clk);
        check("stall_idle_ready", {31'b0, req_ready}, 32'd1);
        check("stall_idle_valid", {31'b0, rsp_valid}, 32'd0);

        // Reset during CAP of a partial write
        req_valid = 1'b1; req_addr = 9'h1A5; req_we = 1'b1; req_be = 4'b0001; req_wdata = 32'hFF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("mid_rd_en", {31'b0, sram_en}, 32'd1);
        @(negedge clk);
        check("mid_cap_en", {31'b0, sram_en}, 32'd0);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (sram_en) cnt++;
            if (i == 1) reset = 1'b1;
        end
        check("mid_no_wr", cnt, 0);
        check("mid_ready", {31'b0, req_ready}, 32'd1);
        check("mid_valid", {31'b0, rsp_valid}, 32'd0);
        do_req(9'h1A5, 1'b0, 4'b0000, 32'h0, 1, lat, en_cnt, wen_cnt, wdat, rdat, unstable);
        check("mid_readback", rdat, 32'hDEAD55EF);

        // Strobe spacing and idle-zero rules across all transactions
        check("en_adjacent", adj_viol, 0);
        check("idle_zero", zero_viol, 0);
        check("sram_addr", addr_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
